feature_frame_assembler: RTL and testbench

FEATURE_FRAME_ASSEMBLER -- requirements
Module: feature_frame_assembler

---
 rtl/feature_frame_assembler.sv | 137 +++++++++++++
 tb/tb_feature_frame_assembler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/feature_frame_assembler.sv
// rtl/feature_frame_assembler.sv - collects a fixed-length frame of feature words into a parallel vector
module feature_frame_assembler #(
    parameter int DATA_WIDTH = 32,
    parameter int N_FEATURES = 28
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [DATA_WIDTH-1:0]                  s_data,
    input  logic                                   s_valid,
    input  logic                                   s_last,
    output logic                                   s_ready,
    output logic [N_FEATURES-1:0][DATA_WIDTH-1:0]  pkt_features,
    output logic                                   pkt_valid,
    output logic                                   err_short,
    output logic                                   err_long,
    output logic [15:0]                            frame_count,
    output logic [15:0]                            err_count
);

    localparam int IDX_W = (N_FEATURES > 1) ? $clog2(N_FEATURES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_FEATURES - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        EMIT    = 2'd2
    } state_t;

    state_t                                 state_q, state_d;
    logic [IDX_W-1:0]                       idx_q, idx_d;
    logic [N_FEATURES-1:0][DATA_WIDTH-1:0]  buf_q, buf_d;
    logic [N_FEATURES-1:0][DATA_WIDTH-1:0]  feat_q, feat_d;
    logic                                   pkt_valid_q, pkt_valid_d;
    logic                                   err_short_q, err_short_d;
    logic                                   err_long_q, err_long_d;
    logic [15:0]                            frame_count_q, frame_count_d;
    logic [15:0]                            err_count_q, err_count_d;
    logic                                   accept;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Handshake: the EMIT cycle and reset both hold off the upstream source.
    always_comb begin
        s_ready = !rst && (state_q != EMIT);
        accept  = s_valid && s_ready;
    end

    // Next-state logic: the output vector and frame count are loaded on entry to EMIT so
    // they are already valid while pkt_valid is high.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        buf_d         = buf_q;
        feat_d        = feat_q;
        pkt_valid_d   = 1'b0;
        err_short_d   = 1'b0;
        err_long_d    = 1'b0;
        frame_count_d = frame_count_q;
        err_count_d   = err_count_q;
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    buf_d[idx_q] = s_data;
                    if (s_last) begin
                        idx_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d       = EMIT;
                            feat_d        = buf_d;
                            pkt_valid_d   = 1'b1;
                            frame_count_d = sat_inc(frame_count_q);
                        end else begin
                            err_short_d = 1'b1;
                            err_count_d = sat_inc(err_count_q);
                        end
                    end else if (idx_q == IDX_LAST) begin
                        state_d = DRAIN;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (accept && s_last) begin
                    state_d     = COLLECT;
                    err_long_d  = 1'b1;
                    err_count_d = sat_inc(err_count_q);
                end
            end
            EMIT: begin
                state_d = COLLECT;
            end
            default: begin
                state_d = COLLECT;
                idx_d   = '0;
            end
        endcase
    end

    // State register with synchronous reset; the collect buffer needs no reset because
    // every good frame overwrites all entries before it is emitted.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
        if (rst) begin
            state_q       <= COLLECT;
            idx_q         <= '0;
            feat_q        <= '0;
            pkt_valid_q   <= 1'b0;
            err_short_q   <= 1'b0;
            err_long_q    <= 1'b0;
            frame_count_q <= '0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            feat_q        <= feat_d;
            pkt_valid_q   <= pkt_valid_d;
            err_short_q   <= err_short_d;
            err_long_q    <= err_long_d;
            frame_count_q <= frame_count_d;
            err_count_q   <= err_count_d;
        end
    end

    // Pulses are masked while reset is asserted so a reset landing on EMIT shows no event.
    always_comb begin
        pkt_features = feat_q;
        pkt_valid    = pkt_valid_q && !rst;
        err_short    = err_short_q && !rst;
        err_long     = err_long_q && !rst;
        frame_count  = frame_count_q;
        err_count    = err_count_q;
    end

endmodule

// File: tb/tb_feature_frame_assembler.sv
// tb/tb_feature_frame_assembler.sv - scoreboard bench for feature_frame_assembler
module tb_feature_frame_assembler;

    localparam int DW = 32;
    localparam int NF = 28;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [DW-1:0]            s_data;
    logic                     s_valid;
    logic                     s_last;
    logic                     s_ready;
    logic [NF-1:0][DW-1:0]    pkt_features;
    logic                     pkt_valid;
    logic                     err_short;
    logic                     err_long;
    logic [15:0]              frame_count;
    logic [15:0]              err_count;

    feature_frame_assembler #(.DATA_WIDTH(DW), .N_FEATURES(NF)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .pkt_features (pkt_features),
        .pkt_valid    (pkt_valid),
        .err_short    (err_short),
        .err_long     (err_long),
        .frame_count  (frame_count),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                    kind;   // 0 = packet, 1 = short, 2 = long
        logic [NF-1:0][DW-1:0] feat;
        logic [15:0]           fc;
        logic [15:0]           ec;
    } exp_t;

    exp_t                  sb[$];
    logic [NF-1:0][DW-1:0] m_feat;
    logic [15:0]           m_fc;
    logic [15:0]           m_ec;
    int                    tests  = 0;
    int                    failed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_feat(input string name, input logic [NF-1:0][DW-1:0] exp);
        int bad = 0;
        for (int i = NF - 1; i >= 0; i--) begin
            if (pkt_features[i] !== exp[i]) bad = i;
        end
        chk(name, 64'(pkt_features[bad]), 64'(exp[bad]));
    endtask

    // Monitor: samples 2 time units after the rising edge and pops one expected event per pulse.
    initial begin
        exp_t e;
        int   kind;
        forever begin
            @(posedge clk);
            #2;
            if (!rst && (pkt_valid || err_short || err_long)) begin
                chk("pulse_exclusive", 64'(int'(pkt_valid) + int'(err_short) + int'(err_long)), 64'd1);
                kind = pkt_valid ? 0 : (err_short ? 1 : 2);
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", 64'(kind), 64'hFF);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind", 64'(kind), 64'(e.kind));
                    chk("s_ready_at_event", 64'(s_ready), 64'(e.kind != 0));
                    chk("frame_count", 64'(frame_count), 64'(e.fc));
                    chk("err_count", 64'(err_count), 64'(e.ec));
                    chk_feat("pkt_features", e.feat);
                end
            end
        end
    end

    // Drives one word from a falling edge and returns at the falling edge after acceptance.
    task automatic send(input logic [DW-1:0] d, input logic l);
        bit ok;
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        do begin
            ok = s_ready;
            @(negedge clk);
            n++;
        end while (!ok && n < 20);
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Pushes the hand-derived outcome of an n-word frame, then sends it.
    task automatic send_frame(input int n, input logic [DW-1:0] base, input bit stall);
        exp_t e;
        logic [NF-1:0][DW-1:0] f;
        f = '0;
        for (int i = 0; i < n && i < NF; i++) f[i] = base + DW'(i);
        if (n == NF) begin
            e.kind = 0;
            m_feat = f;
            m_fc   = (m_fc == 16'hFFFF) ? m_fc : m_fc + 16'd1;
        end else begin
            e.kind = (n < NF) ? 1 : 2;
            m_ec   = (m_ec == 16'hFFFF) ? m_ec : m_ec + 16'd1;
        end
        e.feat = m_feat;
        e.fc   = m_fc;
        e.ec   = m_ec;
        sb.push_back(e);
        for (int i = 0; i < n; i++) begin
            send(base + DW'(i), i == n - 1);
            if (stall && i != n - 1) idle(1);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_pkt_valid"}, 64'(pkt_valid), 64'd0);
        chk({tag, "_err_short"}, 64'(err_short), 64'd0);
        chk({tag, "_err_long"}, 64'(err_long), 64'd0);
        chk({tag, "_frame_count"}, 64'(frame_count), 64'd0);
        chk({tag, "_err_count"}, 64'(err_count), 64'd0);
        chk_feat({tag, "_features"}, '0);
    endtask

    initial begin
        int n;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        m_feat  = '0;
        m_fc    = '0;
        m_ec    = '0;
        repeat (3) @(negedge clk);
        chk("s_ready_in_reset", 64'(s_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("reset");
        chk("s_ready_after_reset", 64'(s_ready), 64'd1);

        // Good frame 0x1..0x1C back-to-back; s_ready low only in the EMIT cycle.
        send_frame(NF, 32'h1, 1'b0);
        chk("s_ready_emit_cycle", 64'(s_ready), 64'd0);
        @(negedge clk);
        chk("s_ready_after_emit", 64'(s_ready), 64'd1);
        chk("features_0", 64'(pkt_features[0]), 64'h1);
        chk("features_27", 64'(pkt_features[27]), 64'h1C);

        // Short frame, long frame, then a good frame after the long one.
        idle(2);
        send_frame(5, 32'h100, 1'b0);
        idle(2);
        send_frame(31, 32'h200, 1'b0);
        idle(1);
        send_frame(NF, 32'h300, 1'b0);

        // Stalled frame, then the next frame is offered during EMIT with s_valid held high.
        idle(1);
        send_frame(NF, 32'h400, 1'b1);
        send_frame(NF, 32'h500, 1'b0);
        idle(2);

        // Reset after 10 words, with a last-flagged word presented during reset.
        for (int i = 0; i < 10; i++) send(32'h900 + DW'(i), 1'b0);
        rst     = 1'b1;
        s_valid = 1'b1;
        s_last  = 1'b1;
        s_data  = 32'hDEAD;
        #1;
        chk("s_ready_during_reset", 64'(s_ready), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_feat  = '0;
        m_fc    = '0;
        m_ec    = '0;
        @(negedge clk);
        chk_quiet("midreset");
        send_frame(NF, 32'h600, 1'b0);
        idle(1);

        // Single-word frame is short.
        send_frame(1, 32'hABC, 1'b0);
        idle(1);

        // Counter saturation from 16'hFFFE.
        force dut.frame_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.frame_count_q;
        m_fc = 16'hFFFE;
        @(negedge clk);
        chk("forced_count", 64'(frame_count), 64'hFFFE);
        send_frame(NF, 32'h700, 1'b0);
        idle(1);
        send_frame(NF, 32'h800, 1'b0);
        idle(2);
        chk("count_saturated", 64'(frame_count), 64'hFFFF);

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
